vcm_focus_seq: RTL and testbench

Autofocus search sequencer for the D8M VCM path. It runs a two-phase hill search over lens positions: a coarse sweep, then a fine sweep around the coarse peak. At each position it commands the VCM over a request/acknowledge link to the I2C writer, waits for the lens and exposure to settle, then samples the per-frame sharpness statistic. It sits between the pixel-statistics block, which produces `SHARP` at frame end, and the VCM I2C writer, which consumes `VCM_DATA`.

---
 rtl/vcm_focus_pkg.sv | 26 ++
 rtl/focus_peak_track.sv | 44 ++++
 rtl/vcm_focus_seq.sv | 172 +++++++++++++++++
 tb/tb_vcm_focus_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcm_focus_pkg.sv
// Shared types and helpers for the VCM autofocus sequencer.
// The DW9714 word carries the 10-bit lens position in bits [13:4].
package vcm_focus_pkg;

  localparam int VCM_POS_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_PARK,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_COARSE,
    PH_FINE
  } phase_e;

  function automatic logic [15:0] dw9714_word(input logic [VCM_POS_W-1:0] pos);
    return {2'b00, pos, 4'h0};
  endfunction

endpackage

// File: rtl/focus_peak_track.sv
// Running maximum of frame sharpness and the lens position where it occurred.
// Strict greater-than compare, so on ties the earliest position is kept.
module focus_peak_track
  import vcm_focus_pkg::*;
#(
  parameter int SHARP_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic [SHARP_W-1:0]   sharp,
  input  logic [VCM_POS_W-1:0] step,
  output logic [VCM_POS_W-1:0] best_step
);

  logic [SHARP_W-1:0]   best_sharp_q, best_sharp_d;
  logic [VCM_POS_W-1:0] best_step_q, best_step_d;

  always_comb begin
    best_sharp_d = best_sharp_q;
    best_step_d  = best_step_q;
    if (clear) begin
      best_sharp_d = '0;
      best_step_d  = '0;
    end else if (sample_en && (sharp > best_sharp_q)) begin
      best_sharp_d = sharp;
      best_step_d  = step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sharp_q <= '0;
      best_step_q  <= '0;
    end else begin
      best_sharp_q <= best_sharp_d;
      best_step_q  <= best_step_d;
    end
  end

  assign best_step = best_step_q;

endmodule

// File: rtl/vcm_focus_seq.sv
// Two-phase (coarse then fine) hill-search autofocus sequencer driving the VCM writer.
// VCM_REQ holds with stable data until VCM_ACK; each position settles for whole frames before sampling.
module vcm_focus_seq
  import vcm_focus_pkg::*;
#(
  parameter int MAX_STEP      = 1023,
  parameter int COARSE_INC    = 64,
  parameter int FINE_INC      = 8,
  parameter int SETTLE_FRAMES = 2,
  parameter int SHARP_W       = 24
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 FRAME_END,
  input  logic [SHARP_W-1:0]   SHARP,
  output logic                 VCM_REQ,
  input  logic                 VCM_ACK,
  output logic [15:0]          VCM_DATA,
  output logic [VCM_POS_W-1:0] STEP,
  output logic [VCM_POS_W-1:0] BEST_STEP,
  output logic                 BUSY,
  output logic                 VCM_END
);

  localparam logic [VCM_POS_W:0]   MAX_W    = (VCM_POS_W+1)'(MAX_STEP);
  localparam logic [VCM_POS_W-1:0] MAX_P    = VCM_POS_W'(MAX_STEP);
  localparam logic [VCM_POS_W:0]   COARSE_W = (VCM_POS_W+1)'(COARSE_INC);
  localparam logic [VCM_POS_W:0]   FINE_W   = (VCM_POS_W+1)'(FINE_INC);
  localparam logic [7:0]           SETTLE_W = 8'(SETTLE_FRAMES);

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [VCM_POS_W-1:0] step_q, step_d;
  logic [VCM_POS_W-1:0] hi_q, hi_d;
  logic [7:0]           settle_cnt_q, settle_cnt_d;
  logic                 vcm_req_q, vcm_req_d;
  logic                 busy_q, busy_d;
  logic                 vcm_end_q, vcm_end_d;

  logic                 peak_clear, peak_sample;
  logic [VCM_POS_W-1:0] best_step;
  logic [VCM_POS_W:0]   best_ext, best_plus, coarse_sum, fine_sum;
  logic [VCM_POS_W-1:0] lo_w, hi_w;

  // 11-bit sums so a step past MAX_STEP is detected instead of wrapping.
  assign best_ext   = {1'b0, best_step};
  assign best_plus  = best_ext + COARSE_W;
  assign coarse_sum = {1'b0, step_q} + COARSE_W;
  assign fine_sum   = {1'b0, step_q} + FINE_W;
  assign lo_w       = (best_ext >= COARSE_W) ? VCM_POS_W'(best_ext - COARSE_W) : '0;
  assign hi_w       = (best_plus > MAX_W) ? MAX_P : best_plus[VCM_POS_W-1:0];

  focus_peak_track #(.SHARP_W(SHARP_W)) u_peak (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .clear     (peak_clear),
    .sample_en (peak_sample),
    .sharp     (SHARP),
    .step      (step_q),
    .best_step (best_step)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    step_d       = step_q;
    hi_d         = hi_q;
    settle_cnt_d = settle_cnt_q;
    vcm_req_d    = vcm_req_q;
    busy_d       = busy_q;
    vcm_end_d    = vcm_end_q;
    peak_clear   = 1'b0;
    peak_sample  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          phase_d      = PH_COARSE;
          step_d       = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
          vcm_end_d    = 1'b0;
          vcm_req_d    = 1'b1;
          peak_clear   = 1'b1;
          state_d      = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (vcm_req_q && VCM_ACK) begin
          vcm_req_d    = 1'b0;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (SETTLE_FRAMES == 0) begin
          state_d = ST_SAMPLE;
        end else if (FRAME_END) begin
          if (settle_cnt_q + 8'd1 == SETTLE_W) begin
            settle_cnt_d = '0;
            state_d      = ST_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
      end
      ST_SAMPLE: begin
        if (FRAME_END) begin
          peak_sample = 1'b1;
          state_d     = ST_NEXT;
        end
      end
      ST_NEXT: begin
        vcm_req_d = 1'b1;
        state_d   = ST_MOVE;
        if (phase_q == PH_COARSE) begin
          if (coarse_sum <= MAX_W) begin
            step_d = coarse_sum[VCM_POS_W-1:0];
          end else begin
            phase_d = PH_FINE;
            step_d  = lo_w;
            hi_d    = hi_w;
          end
        end else if (fine_sum <= {1'b0, hi_q}) begin
          step_d = fine_sum[VCM_POS_W-1:0];
        end else begin
          step_d  = best_step;
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        if (vcm_req_q && VCM_ACK) begin
          vcm_req_d = 1'b0;
          busy_d    = 1'b0;
          vcm_end_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_COARSE;
      step_q       <= '0;
      hi_q         <= '0;
      settle_cnt_q <= '0;
      vcm_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      vcm_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_q       <= step_d;
      hi_q         <= hi_d;
      settle_cnt_q <= settle_cnt_d;
      vcm_req_q    <= vcm_req_d;
      busy_q       <= busy_d;
      vcm_end_q    <= vcm_end_d;
    end
  end

  assign VCM_REQ   = vcm_req_q;
  assign VCM_DATA  = dw9714_word(step_q);
  assign STEP      = step_q;
  assign BEST_STEP = best_step;
  assign BUSY      = busy_q;
  assign VCM_END   = vcm_end_q;

endmodule

// File: tb/tb_vcm_focus_seq.sv
// Directed bench for vcm_focus_seq: sharpness profiles chosen per scenario, acks 3 cycles after request.
module tb_vcm_focus_seq;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        FRAME_END = 1'b0;
  logic [23:0] SHARP = '0;
  logic        VCM_ACK = 1'b0;
  logic        VCM_REQ;
  logic [15:0] VCM_DATA;
  logic [9:0]  STEP;
  logic [9:0]  BEST_STEP;
  logic        BUSY;
  logic        VCM_END;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  bit ack_en = 1'b1;
  logic [9:0] moves[$];

  vcm_focus_seq dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .FRAME_END (FRAME_END),
    .SHARP     (SHARP),
    .VCM_REQ   (VCM_REQ),
    .VCM_ACK   (VCM_ACK),
    .VCM_DATA  (VCM_DATA),
    .STEP      (STEP),
    .BEST_STEP (BEST_STEP),
    .BUSY      (BUSY),
    .VCM_END   (VCM_END)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] sharp_of(input int m, input logic [9:0] s);
    int v;
    int d;
    d = (int'(s) > 300) ? int'(s) - 300 : 300 - int'(s);
    case (m)
      0: begin v = 1000 - 2 * d; if (v < 0) v = 0; end
      1: v = 2000 - int'(s);
      2: v = int'(s);
      3: v = 500;
      default: v = 0;
    endcase
    return 24'(v);
  endfunction

  function automatic logic [9:0] mv(input int i);
    if (i < moves.size()) return moves[i];
    return 10'h3ff;
  endfunction

  // I2C writer model: acknowledges 3 cycles after a request and logs the acknowledged position.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge CLK);
      if (VCM_ACK) begin
        VCM_ACK = 1'b0;
        cnt = 0;
      end else if (VCM_REQ && ack_en) begin
        cnt++;
        if (cnt == 3) begin
          VCM_ACK = 1'b1;
          moves.push_back(STEP);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Frame source: one FRAME_END every 16 cycles, sharpness derived from the lens position.
  initial begin
    forever begin
      repeat (15) @(negedge CLK);
      FRAME_END = 1'b1;
      SHARP = sharp_of(mode, STEP);
      @(negedge CLK);
      FRAME_END = 1'b0;
    end
  end

  task automatic start_search(input int m);
    mode = m;
    moves.delete();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    vectors++;
    if (VCM_REQ !== 1'b1 || BUSY !== 1'b1 || VCM_END !== 1'b0) begin
      miscompares++;
      $display("FAIL start_req REQ=%b BUSY=%b END=%b required 1 1 0", VCM_REQ, BUSY, VCM_END);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (VCM_END !== 1'b1 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (VCM_END !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL search_done END=%b BUSY=%b required 1 0", VCM_END, BUSY);
    end
  endtask

  task automatic check_result(input string name, input int n_moves, input int fi,
                              input logic [9:0] f_first, input int li, input logic [9:0] f_last,
                              input logic [9:0] best);
    vectors++;
    if (moves.size() != n_moves) begin
      miscompares++;
      $display("FAIL %s move_count got %0d required %0d", name, moves.size(), n_moves);
    end
    vectors++;
    if (mv(fi) !== f_first || mv(li) !== f_last) begin
      miscompares++;
      $display("FAIL %s fine_window got %0d..%0d required %0d..%0d", name, mv(fi), mv(li), f_first, f_last);
    end
    vectors++;
    if (BEST_STEP !== best || STEP !== best || mv(n_moves - 1) !== best) begin
      miscompares++;
      $display("FAIL %s park BEST=%0d STEP=%0d parkmove=%0d required %0d", name, BEST_STEP, STEP, mv(n_moves - 1), best);
    end
    vectors++;
    if (VCM_DATA !== {2'b00, best, 4'h0} || VCM_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL %s vcm_data got %h req=%b required %h 0", name, VCM_DATA, VCM_REQ, {2'b00, best, 4'h0});
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if (VCM_REQ !== 1'b0 || BUSY !== 1'b0 || VCM_END !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl REQ=%b BUSY=%b END=%b required 0 0 0", VCM_REQ, BUSY, VCM_END);
    end
    vectors++;
    if (VCM_DATA !== 16'h0000 || STEP !== 10'd0 || BEST_STEP !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_data DATA=%h STEP=%0d BEST=%0d required 0 0 0", VCM_DATA, STEP, BEST_STEP);
    end
  endtask

  task automatic test_single_peak();
    start_search(0);
    wait_end();
    vectors++;
    if (mv(0) !== 10'd0 || mv(15) !== 10'd960) begin
      miscompares++;
      $display("FAIL peak_coarse got %0d..%0d required 0..960", mv(0), mv(15));
    end
    check_result("single_peak", 34, 16, 10'd256, 32, 10'd384, 10'd296);
    vectors++;
    if (VCM_DATA !== 16'h1280) begin
      miscompares++;
      $display("FAIL peak_word got %h required 1280", VCM_DATA);
    end
  endtask

  task automatic test_low_edge();
    start_search(1);
    wait_end();
    check_result("low_edge", 26, 16, 10'd0, 24, 10'd64, 10'd0);
  endtask

  task automatic test_high_edge();
    start_search(2);
    wait_end();
    check_result("high_edge", 33, 16, 10'd896, 31, 10'd1016, 10'd1016);
  endtask

  task automatic test_tie_flat();
    start_search(3);
    wait_end();
    check_result("tie_500", 26, 16, 10'd0, 24, 10'd64, 10'd0);
    start_search(4);
    wait_end();
    check_result("flat_0", 26, 16, 10'd0, 24, 10'd64, 10'd0);
  endtask

  task automatic test_handshake();
    int n = 0;
    int bad = 0;
    logic [15:0] data0;
    start_search(1);
    while (moves.size() < 5 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    ack_en = 1'b0;
    repeat (2) @(negedge CLK);
    n = 0;
    while (VCM_REQ !== 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    data0 = VCM_DATA;
    vectors++;
    if (data0 !== 16'h1400 || moves.size() != 5) begin
      miscompares++;
      $display("FAIL stall_pos data=%h moves=%0d required 1400 5", data0, moves.size());
    end
    for (int i = 0; i < 1000; i++) begin
      START = (i == 500);
      @(negedge CLK);
      if (VCM_REQ !== 1'b1 || VCM_DATA !== data0 || moves.size() != 5 || BUSY !== 1'b1) bad++;
    end
    START = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold %0d bad cycles, required 0", bad);
    end
    ack_en = 1'b1;
    wait_end();
    vectors++;
    if (mv(5) !== 10'd320) begin
      miscompares++;
      $display("FAIL stall_resume move5=%0d required 320", mv(5));
    end
    check_result("handshake", 26, 16, 10'd0, 24, 10'd64, 10'd0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start_search(0);
    while (moves.size() < 20 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (moves.size() < 20) begin
      miscompares++;
      $display("FAIL mid_reach moves=%0d required 20", moves.size());
    end
    #2 RESET_N = 1'b0;
    #1;
    vectors++;
    if (VCM_REQ !== 1'b0 || BUSY !== 1'b0 || VCM_END !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl REQ=%b BUSY=%b END=%b required 0 0 0", VCM_REQ, BUSY, VCM_END);
    end
    vectors++;
    if (VCM_DATA !== 16'h0000 || STEP !== 10'd0 || BEST_STEP !== 10'd0) begin
      miscompares++;
      $display("FAIL mid_reset_data DATA=%h STEP=%0d BEST=%0d required 0 0 0", VCM_DATA, STEP, BEST_STEP);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    start_search(0);
    wait_end();
    check_result("restart", 34, 16, 10'd256, 32, 10'd384, 10'd296);
    vectors++;
    if (mv(0) !== 10'd0) begin
      miscompares++;
      $display("FAIL restart_origin first=%0d required 0", mv(0));
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_low_edge();
    test_high_edge();
    test_tie_flat();
    test_handshake();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
